// File: rtl/conv_seq.sv
// conv_seq: corelet instruction sequencer for one convolution job.
// For each kernel index it fills L0 with weights, loads them into the MAC
// array, fills L0 with activations, executes, and then drains the OFIFO
// into psum memory. Every output is registered, so inst/busy/done show the
// decode of the state that was current during the previous cycle.
// Optional feature: define CONV_SEQ_PERF_EN to add the cyc_cnt[31:0] output.
// cyc_cnt counts busy cycles of the current or most recent job.
module conv_seq #(
  parameter int          row    = 8,
  parameter int          col    = 8,
  parameter int          n_act  = 36,
  parameter int          n_kij  = 9,
  parameter logic [10:0] w_base = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        acc_final,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0] cyc_cnt
`endif
);

  // Instruction bundle bit positions.
  localparam int B_ACC    = 33;
  localparam int B_CEN_P  = 32;
  localparam int B_WEN_P  = 31;
  localparam int B_AP_HI  = 30;
  localparam int B_AP_LO  = 20;
  localparam int B_CEN_X  = 19;
  localparam int B_WEN_X  = 18;
  localparam int B_AX_HI  = 17;
  localparam int B_AX_LO  = 7;
  localparam int B_OF_RD  = 6;
  localparam int B_L0_RD  = 3;
  localparam int B_L0_WR  = 2;
  localparam int B_EXEC   = 1;
  localparam int B_LOAD   = 0;

  // Idle bundle: both memories deselected and write-disabled (bits 32, 31,
  // 19, 18 high), everything else low.
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  // Phase counter must reach row+col-1 (W_LOAD) and n_act (A_FILL).
  localparam int CMAX = ((row + col) > (n_act + 1)) ? (row + col) : (n_act + 1);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int KW   = (n_kij > 1) ? $clog2(n_kij) : 1;
  localparam int OW   = $clog2(n_act + 1);

  localparam logic [CW-1:0] C_ROW       = CW'(row);
  localparam logic [CW-1:0] C_WLOAD_END = CW'(row + col - 1);
  localparam logic [CW-1:0] C_NACT      = CW'(n_act);
  localparam logic [CW-1:0] C_EXEC_END  = CW'(n_act - 1);
  localparam logic [KW-1:0] K_LAST      = KW'(n_kij - 1);
  localparam logic [OW-1:0] O_NACT      = OW'(n_act);

  typedef enum logic [2:0] {
    IDLE,
    W_FILL,
    W_LOAD,
    A_FILL,
    EXEC,
    DRAIN,
    DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [KW-1:0] r_kij;
  logic [OW-1:0] r_o;
  logic          r_pw_valid;
  logic [10:0]   r_pw_addr;
  logic [33:0]   r_inst;
  logic          r_busy;
  logic          r_done;

  state_t        w_next_state;
  logic [CW-1:0] w_cnt_next;
  logic [KW-1:0] w_kij_next;
  logic [OW-1:0] w_o_next;
  logic          w_pw_valid_next;
  logic [10:0]   w_pw_addr_next;
  logic [33:0]   w_inst;
  logic          w_busy;
  logic          w_done;
  logic [10:0]   w_waddr;
  logic [10:0]   w_paddr;

  // Addresses wrap modulo 2^11; operands are cast to 11 bits before the math.
  assign w_waddr = w_base + (11'(r_kij) * 11'(row)) + 11'(r_cnt);
  assign w_paddr = (11'(r_kij) * 11'(n_act)) + 11'(r_o);

  // Next-state, counter and instruction decode for the current state.
  always_comb begin
    w_next_state    = r_state;
    w_cnt_next      = r_cnt;
    w_kij_next      = r_kij;
    w_o_next        = r_o;
    w_pw_valid_next = 1'b0;
    w_pw_addr_next  = r_pw_addr;
    w_inst          = IDLE_INST;
    w_busy          = (r_state != IDLE);
    w_done          = 1'b0;

    // The pmem write stage trails each OFIFO read by one cycle.
    if (r_pw_valid) begin
      w_inst[B_CEN_P]           = 1'b0;
      w_inst[B_WEN_P]           = 1'b0;
      w_inst[B_AP_HI:B_AP_LO]   = r_pw_addr;
    end

    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = W_FILL;
          w_cnt_next   = '0;
          w_kij_next   = '0;
          w_o_next     = '0;
        end
      end

      W_FILL: begin
        if (r_cnt < C_ROW) begin
          w_inst[B_CEN_X]         = 1'b0;
          w_inst[B_AX_HI:B_AX_LO] = w_waddr;
        end
        if (r_cnt != '0) begin
          w_inst[B_L0_WR] = 1'b1;
        end
        if (r_cnt == C_ROW) begin
          w_next_state = W_LOAD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      W_LOAD: begin
        w_inst[B_L0_RD] = 1'b1;
        w_inst[B_LOAD]  = 1'b1;
        if (r_cnt == C_WLOAD_END) begin
          w_next_state = A_FILL;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      A_FILL: begin
        if (r_cnt < C_NACT) begin
          w_inst[B_CEN_X]         = 1'b0;
          w_inst[B_AX_HI:B_AX_LO] = 11'(r_cnt);
        end
        if (r_cnt != '0) begin
          w_inst[B_L0_WR] = 1'b1;
        end
        if (r_cnt == C_NACT) begin
          w_next_state = EXEC;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      EXEC: begin
        w_inst[B_L0_RD] = 1'b1;
        w_inst[B_EXEC]  = 1'b1;
        if (r_cnt == C_EXEC_END) begin
          w_next_state = DRAIN;
          w_cnt_next   = '0;
          w_o_next     = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      DRAIN: begin
        w_inst[B_ACC] = (r_kij == K_LAST) ? acc_final : 1'b1;
        if (r_o != O_NACT) begin
          // Stall here for as long as the OFIFO has nothing to give.
          if (ofifo_valid) begin
            w_inst[B_OF_RD] = 1'b1;
            w_pw_valid_next = 1'b1;
            w_pw_addr_next  = w_paddr;
            w_o_next        = r_o + 1'b1;
          end
        end else begin
          // All reads issued; the last pmem write goes out this cycle.
          w_cnt_next = '0;
          if (r_kij == K_LAST) begin
            w_next_state = DONE;
          end else begin
            w_kij_next   = r_kij + 1'b1;
            w_next_state = W_FILL;
          end
        end
      end

      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, counters, pmem write stage and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_kij      <= '0;
      r_o        <= '0;
      r_pw_valid <= 1'b0;
      r_pw_addr  <= '0;
      r_inst     <= IDLE_INST;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_cnt_next;
      r_kij      <= w_kij_next;
      r_o        <= w_o_next;
      r_pw_valid <= w_pw_valid_next;
      r_pw_addr  <= w_pw_addr_next;
      r_inst     <= w_inst;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] r_cyc_cnt;

  // Busy-cycle counter: cleared by an accepted start, frozen while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_cyc_cnt <= '0;
    end else if (r_busy) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: directed bench for conv_seq with a scoreboard of expected
// xmem read addresses and pmem write addresses.
module tb_conv_seq;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int NACT = 36;
  localparam int NKIJ = 9;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        acc_final;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] cyc_cnt;
`endif

  conv_seq #(
    .row(ROW), .col(COL), .n_act(NACT), .n_kij(NKIJ), .w_base(11'h400)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .acc_final(acc_final),
    .ofifo_valid(ofifo_valid),
    .inst(inst),
    .busy(busy),
    .done(done)
`ifdef CONV_SEQ_PERF_EN
    ,
    .cyc_cnt(cyc_cnt)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  logic [10:0] xQ[$];
  logic [10:0] pQ[$];
  int  modelKij, modelO;
  bit  inDrain, pendPmem, prevCenLow, prevExec;
  bit  lastValid, lastAccFinal, lastReset;
  bit  doneFlag, execNow;
  int  doneCount, pmemWrites, acc0Reads, rdCount;
  int  loadCycles, execCycles, l0wrCycles, l0rdCycles, busyCycles;
  logic [10:0] lastPmemAddr, firstXAddr;
  bit  firstXSeen;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushFill(input int k);
    for (int i = 0; i < ROW; i++) xQ.push_back(11'(11'h400 + k * ROW + i));
    for (int i = 0; i < NACT; i++) xQ.push_back(11'(i));
  endtask

  task automatic modelReset();
    xQ.delete();
    pQ.delete();
    modelKij   = 0;
    modelO     = 0;
    inDrain    = 1'b0;
    pendPmem   = 1'b0;
    prevCenLow = 1'b0;
    prevExec   = 1'b0;
  endtask

  task automatic clearStats();
    doneCount = 0; pmemWrites = 0; acc0Reads = 0; rdCount = 0;
    loadCycles = 0; execCycles = 0; l0wrCycles = 0; l0rdCycles = 0;
    busyCycles = 0; doneFlag = 1'b0; firstXSeen = 1'b0;
    lastPmemAddr = '0; firstXAddr = '0;
  endtask

  // One clock cycle, then check the observed bundle against the model.
  task automatic tick();
    logic [10:0] a;
    lastValid    = ofifo_valid;
    lastAccFinal = acc_final;
    lastReset    = reset;
    @(posedge clk);
    #1;
    if (lastReset) modelReset();
    execNow = inst[1];
    if (prevExec && !execNow) inDrain = 1'b1;
    check("l0_wr_lag", 34'(inst[2]), 34'(prevCenLow));
    check("ofifo_rd", 34'(inst[6]), 34'(inDrain & lastValid));
    check("pmem_ctl", 34'(inst[32:31]), pendPmem ? 34'd0 : 34'd3);
    check("load_exec_excl", 34'(inst[1] & inst[0]), 34'd0);
    check("ififo_tied", 34'(inst[5:4]), 34'd0);
    if (!inst[19]) begin
      check("xmem_expected", 34'(xQ.size() != 0), 34'd1);
      check("xmem_wen", 34'(inst[18]), 34'd1);
      if (xQ.size() != 0) begin
        a = xQ.pop_front();
        check("xmem_addr", 34'(inst[17:7]), 34'(a));
      end
      if (!firstXSeen) begin
        firstXSeen = 1'b1;
        firstXAddr = inst[17:7];
      end
    end
    if (!inst[32] && pQ.size() != 0) begin
      a = pQ.pop_front();
      check("pmem_addr", 34'(inst[30:20]), 34'(a));
      lastPmemAddr = inst[30:20];
      pmemWrites++;
    end
    pendPmem = inst[6];
    if (inst[6]) begin
      rdCount++;
      check("acc", 34'(inst[33]), (modelKij < NKIJ - 1) ? 34'd1 : 34'(lastAccFinal));
      if (!inst[33]) acc0Reads++;
      pQ.push_back(11'(modelKij * NACT + modelO));
      modelO++;
      if (modelO == NACT) begin
        modelO  = 0;
        inDrain = 1'b0;
        if (modelKij < NKIJ - 1) begin
          modelKij++;
          pushFill(modelKij);
        end
      end
    end
    prevCenLow = !inst[19];
    prevExec   = execNow;
    if (inst[0]) loadCycles++;
    if (inst[1]) execCycles++;
    if (inst[2]) l0wrCycles++;
    if (inst[3]) l0rdCycles++;
    if (busy) busyCycles++;
    if (done) begin
      doneCount++;
      doneFlag = 1'b1;
    end
  endtask

  task automatic startJob();
    modelKij = 0;
    modelO   = 0;
    pushFill(0);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic runUntilDone(input int bound, input bit randValid);
    int n = 0;
    while (!doneFlag && n < bound) begin
      if (randValid) ofifo_valid = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("done_timeout", 34'(doneFlag), 34'd1);
    ofifo_valid = 1'b1;
    tick();
    tick();
  endtask

  task automatic checkJobEnd(input int expAcc0);
    check("done_count", 34'(doneCount), 34'd1);
    check("pmem_writes", 34'(pmemWrites), 34'(NKIJ * NACT));
    check("last_pmem_addr", 34'(lastPmemAddr), 34'd323);
    check("acc0_reads", 34'(acc0Reads), 34'(expAcc0));
    check("load_cycles", 34'(loadCycles), 34'(NKIJ * (ROW + COL)));
    check("exec_cycles", 34'(execCycles), 34'(NKIJ * NACT));
    check("l0_wr_cycles", 34'(l0wrCycles), 34'(NKIJ * (ROW + NACT)));
    check("l0_rd_cycles", 34'(l0rdCycles), 34'(NKIJ * (ROW + COL + NACT)));
    check("first_xmem_addr", 34'(firstXAddr), 34'h400);
    check("xq_drained", 34'(xQ.size()), 34'd0);
    check("pq_drained", 34'(pQ.size()), 34'd0);
    check("busy_after_job", 34'(busy), 34'd0);
`ifdef CONV_SEQ_PERF_EN
    check("cyc_cnt_job", 34'(cyc_cnt), 34'(busyCycles));
`endif
  endtask

  // Directed sequence: reset, stalled full job, mid-job reset, restart.
  initial begin
    int n;
    int rdBefore;
    reset = 1'b1; start = 1'b0; acc_final = 1'b0; ofifo_valid = 1'b0;
    modelReset();
    clearStats();

    tick();
    tick();
    check("reset_inst", inst, IDLE_INST);
    check("reset_busy", 34'(busy), 34'd0);
    check("reset_done", 34'(done), 34'd0);
`ifdef CONV_SEQ_PERF_EN
    check("reset_cyc_cnt", 34'(cyc_cnt), 34'd0);
`endif
    reset = 1'b0;
    tick();
    check("release_inst", inst, IDLE_INST);
    check("release_busy", 34'(busy), 34'd0);

    // Job 1: acc_final=0, drain of kij 0 stalled for 20 cycles.
    clearStats();
    startJob();
    tick();
    check("busy_after_start", 34'(busy), 34'd1);
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!inDrain && n < 500) begin
      tick();
      n++;
    end
    check("drain_reached", 34'(inDrain), 34'd1);
    rdBefore = rdCount;
    for (int i = 0; i < 20; i++) tick();
    check("stall_no_rd", 34'(rdCount - rdBefore), 34'd0);
    ofifo_valid = 1'b1;
    runUntilDone(4000, 1'b0);
    checkJobEnd(NACT);

    // Job 2: random ofifo_valid, reset during EXEC of kij 3.
    clearStats();
    acc_final = 1'b1;
    startJob();
`ifdef CONV_SEQ_PERF_EN
    check("cyc_cnt_cleared", 34'(cyc_cnt), 34'd0);
`endif
    n = 0;
    while (!(modelKij == 3 && execNow) && n < 3000) begin
      ofifo_valid = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("kij3_exec_reached", 34'(modelKij == 3 && execNow), 34'd1);
    reset = 1'b1;
    ofifo_valid = 1'b0;
    tick();
    check("midjob_reset_inst", inst, IDLE_INST);
    check("midjob_reset_busy", 34'(busy), 34'd0);
    check("midjob_reset_done", 34'(done), 34'd0);
    reset = 1'b0;
    tick();

    // start together with reset must be ignored.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("start_in_reset_ignored", 34'(busy), 34'd0);

    // Job 3: clean restart, ofifo_valid always high, acc_final=1.
    clearStats();
    ofifo_valid = 1'b1;
    startJob();
    runUntilDone(4000, 1'b0);
    checkJobEnd(0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
